scanner_node: RTL and testbench

SCANNER_NODE -- requirements
Module: scanner_node

---
 rtl/scanner_if.sv | 21 ++
 rtl/scanner_node.sv | 72 +++++++
 tb/tb_scanner_node.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/scanner_if.sv
// scanner_if: user request, peer message and status bundle of one scanner node
interface scanner_if #(
    parameter int CW = 4
);
    logic          start_system;
    logic          start_scan;
    logic          start_transfer;
    logic [2:0]    peer_comm;
    logic [2:0]    comm;
    logic [2:0]    state;
    logic [CW-1:0] count;
    logic [7:0]    flush_total;
    modport master (
        output start_system, start_scan, start_transfer, peer_comm,
        input  comm, state, count, flush_total
    );
    modport slave (
        input  start_system, start_scan, start_transfer, peer_comm,
        output comm, state, count, flush_total
    );
endinterface

// File: rtl/scanner_node.sv
// scanner_node: sample buffer that collects, hands off or flushes data in step with a peer node
module scanner_node #(
    parameter int DEPTH      = 10,
    parameter int STANDBY_AT = 8,
    parameter int SAMPLE_DIV = 1,
    parameter int XFER_RATE  = 1,
    parameter int FLUSH_RATE = 1
) (
    input logic       clk,
    input logic       reset,
    scanner_if.slave  node_io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [2:0] C_NONE = 3'd0, C_READY = 3'd1, C_GO_STANDBY = 3'd2,
                           C_START_SCAN = 3'd3, C_FLUSH = 3'd4;
    typedef enum logic [2:0] {
        LOW_POWER = 3'd0, STANDBY = 3'd1, COLLECT = 3'd2,
        IDLE = 3'd3, TRANSFER = 3'd4, FLUSH = 3'd5
    } state_t;
    state_t        state_q;
    logic [2:0]    comm_q;
    logic [CW-1:0] count_q, inc_d, xfer_d, flush_d;
    logic [DW-1:0] div_q;
    logic [7:0]    flush_q;
    logic          peer_standby, peer_scan;
    assign peer_standby = node_io.peer_comm == C_GO_STANDBY;
    assign peer_scan    = node_io.peer_comm == C_START_SCAN;
    assign inc_d   = count_q + 1'b1;
    assign xfer_d  = int'(count_q) > XFER_RATE  ? count_q - CW'(XFER_RATE)  : '0;
    assign flush_d = int'(count_q) > FLUSH_RATE ? count_q - CW'(FLUSH_RATE) : '0;
    // The only way back to LOW_POWER is with an empty buffer, so COLLECT always starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOW_POWER;
            comm_q  <= C_NONE;
            count_q <= '0;
            div_q   <= '0;
            flush_q <= '0;
        end else begin
            comm_q <= C_NONE;
            case (state_q)
                LOW_POWER: if (node_io.start_system || peer_standby) state_q <= STANDBY;
                STANDBY: if (node_io.start_scan || peer_scan) begin
                    state_q <= COLLECT;
                    div_q   <= '0;
                end
                COLLECT: if (div_q == DW'(SAMPLE_DIV - 1)) begin
                    div_q   <= '0;
                    count_q <= inc_d;
                    if (inc_d == CW'(DEPTH)) begin
                        state_q <= IDLE;
                        comm_q  <= C_START_SCAN;
                    end else if (inc_d == CW'(STANDBY_AT)) comm_q <= C_GO_STANDBY;
                end else div_q <= div_q + 1'b1;
                IDLE: if (node_io.start_transfer) state_q <= TRANSFER;
                else if (peer_scan) begin
                    state_q <= FLUSH;
                    comm_q  <= C_FLUSH;
                    if (flush_q != 8'hFF) flush_q <= flush_q + 1'b1;
                end else comm_q <= C_READY;
                TRANSFER: if (count_q == '0) state_q <= LOW_POWER; else count_q <= xfer_d;
                FLUSH:    if (count_q == '0) state_q <= LOW_POWER; else count_q <= flush_d;
                default:  state_q <= LOW_POWER;
            endcase
        end
    end
    assign node_io.comm        = comm_q;
    assign node_io.state       = state_q;
    assign node_io.count       = count_q;
    assign node_io.flush_total = flush_q;
endmodule

// File: tb/tb_scanner_node.sv
// tb_scanner_node: scoreboard bench over four nodes (defaults, a cross-connected peer, fast drain, slow sampling)
module tb_scanner_node;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       xconn = 1'b0;
    logic [2:0] pa = '0, pb = '0, pc = '0, pd = '0;
    int         errors = 0;
    int         checks = 0;
    typedef struct { int id; int st; int cnt; int cm; int ft; string nm; } exp_t;
    exp_t sbq[$];
    always #5 clk = ~clk;
    scanner_if #(.CW(4)) if_a ();
    scanner_if #(.CW(4)) if_b ();
    scanner_if #(.CW(5)) if_c ();
    scanner_if #(.CW(4)) if_d ();
    assign if_a.peer_comm = xconn ? if_b.comm : pa;
    assign if_b.peer_comm = xconn ? if_a.comm : pb;
    assign if_c.peer_comm = pc;
    assign if_d.peer_comm = pd;
    scanner_node u_a (.clk(clk), .reset(rst_n), .node_io(if_a));
    scanner_node u_b (.clk(clk), .reset(rst_n), .node_io(if_b));
    scanner_node #(.DEPTH(16), .XFER_RATE(3)) u_c (.clk(clk), .reset(rst_n), .node_io(if_c));
    scanner_node #(.SAMPLE_DIV(4)) u_d (.clk(clk), .reset(rst_n), .node_io(if_d));
    task automatic ex(input int id, input int st, input int cnt, input int cm, input int ft, input string nm);
        sbq.push_back('{id, st, cnt, cm, ft, nm});
    endtask
    task automatic nx();
        @(negedge clk);
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2;
        for (int i = 0; i < 4; i++) ex(i, 0, 0, 0, 0, "reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    // Drains every expectation due by now: after each rising edge and just after reset falls.
    always @(posedge clk or negedge rst_n) begin : mon
        exp_t e;
        int s, c, m, f;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.id)
                0: begin s = int'(if_a.state); c = int'(if_a.count); m = int'(if_a.comm); f = int'(if_a.flush_total); end
                1: begin s = int'(if_b.state); c = int'(if_b.count); m = int'(if_b.comm); f = int'(if_b.flush_total); end
                2: begin s = int'(if_c.state); c = int'(if_c.count); m = int'(if_c.comm); f = int'(if_c.flush_total); end
                default: begin s = int'(if_d.state); c = int'(if_d.count); m = int'(if_d.comm); f = int'(if_d.flush_total); end
            endcase
            checks++;
            if (s != e.st || c != e.cnt || m != e.cm || f != e.ft) begin
                errors++;
                $display("FAIL %s node%0d @%0t: got state=%0d count=%0d comm=%0d flush_total=%0d, expected state=%0d count=%0d comm=%0d flush_total=%0d",
                         e.nm, e.id, $time, s, c, m, f, e.st, e.cnt, e.cm, e.ft);
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
    initial begin
        {if_a.start_system, if_a.start_scan, if_a.start_transfer} = '0;
        {if_b.start_system, if_b.start_scan, if_b.start_transfer} = '0;
        {if_c.start_system, if_c.start_scan, if_c.start_transfer} = '0;
        {if_d.start_system, if_d.start_scan, if_d.start_transfer} = '0;
        // Node A: full collect, IDLE, transfer beats a simultaneous peer START_SCAN
        do_reset();
        nx(); if_a.start_system = 1'b1; ex(0, 1, 0, 0, 0, "t1_standby");
        nx(); if_a.start_system = 1'b0; if_a.start_scan = 1'b1; ex(0, 2, 0, 0, 0, "t1_collect");
        nx(); if_a.start_scan = 1'b0; ex(0, 2, 1, 0, 0, "t1_count");
        for (int k = 2; k <= 10; k++) begin
            nx(); ex(0, k == 10 ? 3 : 2, k, k == 8 ? 2 : (k == 10 ? 3 : 0), 0, "t1_count");
        end
        nx(); pa = 3'd5; ex(0, 3, 10, 1, 0, "t1_ready");
        nx(); pa = 3'd2; ex(0, 3, 10, 1, 0, "t1_ready_ignore");
        nx(); pa = 3'd3; if_a.start_transfer = 1'b1; ex(0, 4, 10, 0, 0, "t1_xfer_wins");
        nx(); pa = 3'd0; if_a.start_transfer = 1'b0; ex(0, 4, 9, 0, 0, "t1_drain");
        for (int k = 8; k >= 0; k--) begin
            nx(); ex(0, 4, k, 0, 0, "t1_drain");
        end
        nx(); ex(0, 0, 0, 0, 0, "t1_low_power");
        // Nodes A and B cross-connected: B follows A, then A flushes when B fills
        xconn = 1'b1;
        do_reset();
        for (int e = 1; e <= 35; e++) begin
            nx();
            if_a.start_system = (e == 1);
            if_a.start_scan = (e == 2);
            case (e)
                10: begin ex(0, 2, 8, 2, 0, "t2_a_go_standby"); ex(1, 0, 0, 0, 0, "t2_b_wait"); end
                11: begin ex(0, 2, 9, 0, 0, "t2_a_count"); ex(1, 1, 0, 0, 0, "t2_b_standby"); end
                12: begin ex(0, 3, 10, 3, 0, "t2_a_full"); ex(1, 1, 0, 0, 0, "t2_b_standby"); end
                13: begin ex(0, 3, 10, 1, 0, "t2_a_ready"); ex(1, 2, 0, 0, 0, "t2_b_collect"); end
                23: begin ex(0, 3, 10, 1, 0, "t2_a_ready"); ex(1, 3, 10, 3, 0, "t2_b_full"); end
                24: begin ex(0, 5, 10, 4, 1, "t2_a_flush"); ex(1, 3, 10, 1, 0, "t2_b_ready"); end
                25: ex(0, 5, 9, 0, 1, "t2_a_flushing");
                34: begin ex(0, 5, 0, 0, 1, "t2_a_empty"); ex(1, 3, 10, 1, 0, "t2_b_ready"); end
                35: ex(0, 0, 0, 0, 1, "t2_a_low_power");
                default: ;
            endcase
        end
        xconn = 1'b0;
        // Node C (DEPTH 16, XFER_RATE 3): saturating multi-sample drain
        do_reset();
        for (int e = 1; e <= 27; e++) begin
            nx();
            if_c.start_system = (e == 1);
            if_c.start_scan = (e == 2);
            if_c.start_transfer = (e == 20);
            if (e == 10) ex(2, 2, 8, 2, 0, "t3_go_standby");
            if (e == 18) ex(2, 3, 16, 3, 0, "t3_full");
            if (e == 19) ex(2, 3, 16, 1, 0, "t3_ready");
            if (e >= 20 && e <= 26) ex(2, 4, 16 - 3 * (e - 20) > 0 ? 16 - 3 * (e - 20) : 0, 0, 0, "t3_drain");
            if (e == 27) ex(2, 0, 0, 0, 0, "t3_low_power");
        end
        // Node D (SAMPLE_DIV 4): ignored inputs in LOW_POWER, then one sample per 4 cycles
        do_reset();
        nx(); if_d.start_scan = 1'b1; pd = 3'd7; ex(3, 0, 0, 0, 0, "t4_ignore");
        nx(); if_d.start_scan = 1'b0; pd = 3'd0; if_d.start_system = 1'b1; ex(3, 1, 0, 0, 0, "t4_standby");
        nx(); if_d.start_system = 1'b0; if_d.start_scan = 1'b1; ex(3, 2, 0, 0, 0, "t4_collect");
        for (int t = 1; t <= 40; t++) begin
            nx(); if_d.start_scan = 1'b0;
            ex(3, t == 40 ? 3 : 2, t / 4, t == 32 ? 2 : (t == 40 ? 3 : 0), 0, "t4_div");
        end
        // Node A: 260 peer-driven fill/flush rounds, flush_total saturates at 255
        do_reset();
        for (int r = 1; r <= 260; r++) begin
            nx(); pa = 3'd2;
            nx(); pa = 3'd3;
            nx(); pa = 3'd0;
            repeat (9) nx();
            nx(); pa = 3'd3; ex(0, 5, 10, 4, r > 255 ? 255 : r, "t5_flush");
            nx(); pa = 3'd0;
            repeat (9) nx();
            nx(); ex(0, 0, 0, 0, r > 255 ? 255 : r, "t5_low_power");
        end
        // Node A: asynchronous reset at count 5 in COLLECT
        nx(); if_a.start_system = 1'b1;
        nx(); if_a.start_system = 1'b0; if_a.start_scan = 1'b1;
        nx(); if_a.start_scan = 1'b0;
        repeat (3) nx();
        nx(); ex(0, 2, 5, 0, 255, "t6_pre_reset");
        @(negedge clk);
        #2;
        ex(0, 0, 0, 0, 0, "t6_async_reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if_a.start_scan = 1'b1;
        ex(0, 0, 0, 0, 0, "t6_low_power_rules");
        nx(); if_a.start_scan = 1'b0;
        nx();
        nx();
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
